// File: rtl/fetch_pkg.sv
// fetch_pkg
// Types and constants shared by the instruction fetch stage and its queue.
//   fetch_entry_t    : one buffered instruction, {pc, instr}
//   PC_STEP          : byte distance between sequential instruction words
//   RESET_PC_DEFAULT : default fetch address after reset
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
// In-order circular buffer of fetched instructions.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   flush       : synchronous empty; takes priority over push and pop
//   push        : write push_entry at the tail (ignored when full)
//   push_entry  : entry to write
//   pop         : retire the head entry (ignored when empty)
//   count       : current occupancy, 0..DEPTH
//   head        : oldest entry; only meaningful while count != 0
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           push_ok, pop_ok;

    assign push_ok = push && (count_q != FULL_COUNT);
    assign pop_ok  = pop && (count_q != '0);

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while count != 0.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch: issues sequential word requests to instruction memory,
// buffers returned words in an in-order queue for decode, and redirects on
// any non-sequential next-PC reported for the instruction being consumed.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   imem_req_valid/ready/addr        : fetch request handshake
//   imem_resp_valid/data             : in-order responses, always accepted
//   inst_valid/ready/data/pc         : queue head towards decode
//   nextpc_i                         : next PC for inst_pc from next-PC logic
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic [31:0] nextpc_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] occ;
    logic [CW:0]   credit_sum;

    logic          accept, pop, redirect, push;
    fetch_entry_t  head, push_entry;

    // Queue slots plus in-flight requests never exceed DEPTH, so every
    // response that is not dropped is guaranteed a slot.
    assign credit_sum     = {1'b0, occ} + {1'b0, outstanding_q};
    assign imem_req_valid = !rst && (credit_sum < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign inst_valid = !rst && (occ != '0);
    assign inst_data  = head.instr;
    assign inst_pc    = head.pc;

    assign pop      = inst_valid && inst_ready;
    assign redirect = pop && (nextpc_i != head.pc + PC_STEP);

    // Responses still owed to a pre-redirect request are discarded; so is a
    // response landing in the redirect cycle itself.
    assign push       = imem_resp_valid && (drop_cnt_q == '0) && !redirect;
    assign push_entry = '{pc: resp_pc_q, instr: imem_resp_data};

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !imem_resp_valid) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!accept && imem_resp_valid && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - CW'(1);
        end

        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            drop_cnt_d = outstanding_d;
        end else if (imem_resp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end

        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = nextpc_i;
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        // resp_pc follows the oldest live request, i.e. the next word to push.
        resp_pc_d = resp_pc_q;
        if (redirect) begin
            resp_pc_d = nextpc_i;
        end else if (push) begin
            resp_pc_d = resp_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (occ),
        .head       (head)
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] nextpc_i;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .nextpc_i        (nextpc_i)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
    } mreq_t;

    mreq_t        mq[$];
    fetch_entry_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    int unsigned mcyc      = 0;
    int unsigned mem_lat   = 1;
    logic        mem_ready = 1'b1;
    logic        rand_mode = 1'b1;
    logic        ready_en  = 1'b1;
    logic        redir_en  = 1'b0;
    logic [31:0] redir_from = 32'h0;
    logic [31:0] redir_to   = 32'h0;

    // Next-PC logic model: sequential unless the armed redirect PC is at the head.
    assign nextpc_i = (redir_en && inst_pc == redir_from) ? redir_to : inst_pc + 32'd4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[31:16] ^ a[7:0] ^ 16'h0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back('{pc: pc, instr: mem_word(pc)});
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d entries still expected, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Instruction memory: fixed latency, in order, random drive while in reset.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_req_ready  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            mcyc++;
            if (rand_mode) begin
                imem_resp_valid = 1'($urandom_range(0, 1));
                imem_resp_data  = $urandom;
                imem_req_ready  = 1'($urandom_range(0, 1));
            end else begin
                imem_req_ready = mem_ready;
                if (!rst && mq.size() > 0 && mq[0].due <= mcyc) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(mq[0].addr);
                end else begin
                    imem_resp_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (rst) begin
                mq.delete();
            end else begin
                if (imem_resp_valid) begin
                    n_vec++;
                    if (dut.outstanding_q == '0) begin
                        n_err++;
                        $display("FAIL resp_protocol: response with outstanding %0d, required nonzero", dut.outstanding_q);
                    end
                    if (mq.size() > 0) void'(mq.pop_front());
                end
                if (imem_req_valid && imem_req_ready)
                    mq.push_back('{due: mcyc + mem_lat, addr: imem_req_addr});
            end
        end
    end

    // Monitor: consumes only while the scoreboard expects something.
    initial begin
        fetch_entry_t e;
        inst_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            inst_ready = ready_en && (exp_q.size() > 0);
            @(negedge clk);
            if (!rst && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pop: pc %h with nothing expected", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", inst_pc, e.pc);
                    check("inst_data", inst_data, e.instr);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;

        // Reset with random memory activity.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_inst_valid", 32'(inst_valid), 32'd0);
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        end
        tick();

        // Sequential stream, 1-cycle memory.
        for (int i = 0; i < 16; i++) expect_pc(32'(i * 4));
        rand_mode = 1'b0;
        mem_lat   = 1;
        mem_ready = 1'b1;
        rst       = 1'b0;
        #3;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0000_0000);
        check("first_inst_valid", 32'(inst_valid), 32'd0);
        repeat (17) tick();
        check("stream_rate_c17", 32'(exp_q.size()), 32'd1);
        tick();
        check("stream_rate_c18", 32'(exp_q.size()), 32'd0);

        // Backpressure: decode stalls, queue fills to DEPTH, requests stop.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        check("bp_occ", 32'(dut.occ), 32'd4);
        check("bp_req_valid", 32'(imem_req_valid), 32'd0);
        check("bp_inst_valid", 32'(inst_valid), 32'd1);
        for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
        wait_drain(40);

        // Memory stall with fetch_pc at 0x4.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_addr", imem_req_addr, 32'h0000_0004);
            check("stall_req_valid", 32'(imem_req_valid), 32'd1);
            if (i > 0) check("stall_outstanding", 32'(dut.outstanding_q), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        wait_drain(30);

        // Redirect at 0x8 to 0x100 with 3-cycle memory and requests in flight.
        rst        = 1'b1;
        mem_lat    = 3;
        redir_from = 32'h0000_0008;
        redir_to   = 32'h0000_0100;
        redir_en   = 1'b1;
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        expect_pc(32'h100);
        expect_pc(32'h104);
        repeat (2) tick();
        rst = 1'b0;
        wait_drain(60);
        check("redir_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
        redir_en = 1'b0;

        // Redirect to the top of the address space, then wrap to zero.
        rst        = 1'b1;
        mem_lat    = 1;
        redir_from = 32'h0000_0008;
        redir_to   = 32'hFFFF_FFFC;
        redir_en   = 1'b1;
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0);
        expect_pc(32'h4);
        repeat (2) tick();
        rst = 1'b0;
        wait_drain(40);
        redir_en = 1'b0;
        repeat (8) tick();
        check("wrap_occ", 32'(dut.occ), 32'd4);
        check("wrap_head_pc", inst_pc, 32'h0000_0008);

        // Reset with a full queue.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        check("midrst_inst_valid", 32'(inst_valid), 32'd0);
        check("midrst_req_addr", imem_req_addr, 32'h0000_0000);
        check("midrst_req_valid", 32'(imem_req_valid), 32'd1);

        repeat (3) tick();
        check("final_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
